// File: rtl/median_filter_pkg.sv
// Shared types and helpers for the streaming 3x3 rank filter.
package median_filter_pkg;

  // Run-time filter selection, latched when a frame starts.
  typedef enum logic [1:0] {
    MODE_MED = 2'd0,
    MODE_MIN = 2'd1,
    MODE_MAX = 2'd2,
    MODE_BYP = 2'd3
  } mode_t;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Cycles from a window push to its result appearing on the output.
  localparam int SORT_LAT = 3;

  // Widest pixel the shared compare-exchange helper handles; narrower
  // pixels are zero-extended, so unsigned ordering is unchanged.
  localparam int PIX_MAX_W = 16;

  typedef logic [PIX_MAX_W-1:0] pix_t;

  typedef struct packed {
    pix_t lo;
    pix_t hi;
  } pair_t;

  // Compare-exchange: smaller value to lo, larger to hi (unsigned).
  function automatic pair_t cmp_swap(input pix_t a, input pix_t b);
    pair_t r;
    if (a > b) begin
      r.lo = b;
      r.hi = a;
    end else begin
      r.lo = a;
      r.hi = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/median9_sort.sv
// Three-stage 9-input rank unit: median (19 compare-exchanges), min, max
// or centre pass-through. All stages hold when en_i is low.
module median9_sort
  import median_filter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   vld_i,
  input  mode_t                  mode_i,
  input  logic [8:0][DATA_W-1:0] win_i,
  output logic                   vld_o,
  output logic [DATA_W-1:0]      data_o
);

  typedef logic [8:0][DATA_W-1:0] win_t;

  // One compare-exchange on elements a and b of a window.
  function automatic win_t ce(input win_t w, input int a, input int b);
    win_t  o;
    pair_t r;
    o    = w;
    r    = cmp_swap(pix_t'(w[a]), pix_t'(w[b]));
    o[a] = DATA_W'(r.lo);
    o[b] = DATA_W'(r.hi);
    return o;
  endfunction

  // Sort each row of three; afterwards 0/3/6 are row minima, 2/5/8 maxima.
  function automatic win_t sort_rows(input win_t w);
    win_t o;
    o = w;
    o = ce(o, 1, 2); o = ce(o, 4, 5); o = ce(o, 7, 8);
    o = ce(o, 0, 1); o = ce(o, 3, 4); o = ce(o, 6, 7);
    o = ce(o, 1, 2); o = ce(o, 4, 5); o = ce(o, 7, 8);
    return o;
  endfunction

  // Middle part of the median network (column pruning).
  function automatic win_t med_mid(input win_t w);
    win_t o;
    o = w;
    o = ce(o, 0, 3); o = ce(o, 5, 8); o = ce(o, 4, 7);
    o = ce(o, 3, 6); o = ce(o, 1, 4); o = ce(o, 2, 5);
    return o;
  endfunction

  // Final diagonal of the median network; the median ends up in slot 4.
  function automatic logic [DATA_W-1:0] med_fin(input win_t w);
    win_t o;
    o = w;
    o = ce(o, 4, 7); o = ce(o, 4, 2); o = ce(o, 6, 4); o = ce(o, 4, 2);
    return o[4];
  endfunction

  function automatic logic [DATA_W-1:0] min3(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    pair_t r;
    r = cmp_swap(pix_t'(a), pix_t'(b));
    r = cmp_swap(r.lo, pix_t'(c));
    return DATA_W'(r.lo);
  endfunction

  function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    pair_t r;
    r = cmp_swap(pix_t'(a), pix_t'(b));
    r = cmp_swap(r.hi, pix_t'(c));
    return DATA_W'(r.hi);
  endfunction

  win_t              row_p0, row_p1_q, mid_p1, mid_p2_q;
  logic [DATA_W-1:0] ctr_p1_q, ctr_p2_q, min_p1, max_p1, min_p2_q, max_p2_q;
  logic [DATA_W-1:0] res_p2, data_p3_q;
  mode_t             mode_p1_q, mode_p2_q;
  logic              vld_p1_q, vld_p2_q, vld_p3_q;

  // Combinational work feeding each register stage.
  always_comb begin
    row_p0 = sort_rows(win_i);
    mid_p1 = med_mid(row_p1_q);
    min_p1 = min3(row_p1_q[0], row_p1_q[3], row_p1_q[6]);
    max_p1 = max3(row_p1_q[2], row_p1_q[5], row_p1_q[8]);
    unique case (mode_p2_q)
      MODE_MIN: res_p2 = min_p2_q;
      MODE_MAX: res_p2 = max_p2_q;
      MODE_BYP: res_p2 = ctr_p2_q;
      default:  res_p2 = med_fin(mid_p2_q);
    endcase
  end

  // Datapath registers (no reset); the whole pipe freezes while stalled.
  always_ff @(posedge clk) begin
    if (en_i) begin
      // stage p0 -> p1: rows sorted, centre kept for bypass
      row_p1_q  <= row_p0;
      ctr_p1_q  <= win_i[4];
      mode_p1_q <= mode_i;
      // stage p1 -> p2: median pruning, min/max reduction
      mid_p2_q  <= mid_p1;
      min_p2_q  <= min_p1;
      max_p2_q  <= max_p1;
      ctr_p2_q  <= ctr_p1_q;
      mode_p2_q <= mode_p1_q;
    end
  end

  // Valid chain and the output register, which must read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      data_p3_q <= '0;
    end else if (en_i) begin
      vld_p1_q  <= vld_i;
      vld_p2_q  <= vld_p1_q;
      // stage p2 -> p3: mode select into the output register
      vld_p3_q  <= vld_p2_q;
      data_p3_q <= res_p2;
    end
  end

  assign vld_o  = vld_p3_q;
  assign data_o = data_p3_q;

endmodule

// File: rtl/median_filter_stream.sv
// Streaming 3x3 rank filter: raster pixels in, two line buffers build the
// window, a 3-stage sorter produces median/min/max/bypass results.
module median_filter_stream
  import median_filter_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int IMG_W       = 554,
  parameter int IMG_H       = 430,
  parameter int BORDER_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  // Input rows run past the frame during flush (up to IMG_H+1).
  localparam int ROW_W  = $clog2(IMG_H + 2);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int BEAT_W = $clog2(NPIX);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0]  ROW_FLEND = ROW_W'(IMG_H + 1);
  localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NPIX - 1);

  // Window column; index 2 = oldest row (top), 0 = newest (bottom).
  typedef logic [2:0][DATA_W-1:0] col_t;

  state_t            state_q;
  mode_t             mode_q;
  logic              busy_q, done_q;
  logic [COL_W-1:0]  in_col_q, in_col_d, ctr_col_q, ctr_col_d;
  logic [ROW_W-1:0]  in_row_q, in_row_d, ctr_row_q, ctr_row_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  col_t              col_a_q, col_b_q, col_new;
  logic              stall, accept, push, emit, frame_start, beat_acc;
  logic              is_border, zero_border;
  logic [DATA_W-1:0] push_data, border_val;
  logic [8:0][DATA_W-1:0] win;

  assign stall       = out_valid & ~out_ready;
  assign in_ready    = (state_q == RUN) & ~stall;
  assign accept      = in_valid & in_ready;
  // Flush beats feed dummy zeros; only border windows ever see them.
  assign push        = accept | ((state_q == FLUSH) & ~stall);
  assign push_data   = (state_q == RUN) ? in_data : '0;
  // The first IMG_W+1 pushes only prime the line buffers and window.
  assign emit        = push & ((in_row_q > ROW_ONE) |
                               ((in_row_q == ROW_ONE) & (in_col_q != '0)));
  assign frame_start = (state_q == IDLE) & start;
  assign beat_acc    = out_valid & out_ready;
  assign out_last    = out_valid & (beat_q == BEAT_LAST);
  assign busy        = busy_q;
  assign done        = done_q;
  assign col_new     = {lb1_q[in_col_q], lb0_q[in_col_q], push_data};

  // Frame sequencer with registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_MED;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            mode_q  <= mode_t'(mode);
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (accept && (in_row_q == ROW_LAST) && (in_col_q == COL_LAST))
            state_q <= FLUSH;
        end
        FLUSH: begin
          if (push && (in_row_q == ROW_FLEND) && (in_col_q == '0))
            state_q <= DRAIN;
        end
        DRAIN: begin
          if (beat_acc && out_last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Next-state for push position, window-centre position and output beats.
  always_comb begin
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    ctr_col_d = ctr_col_q;
    ctr_row_d = ctr_row_q;
    beat_d    = beat_q;
    if (frame_start) begin
      in_col_d  = '0;
      in_row_d  = '0;
      ctr_col_d = '0;
      ctr_row_d = '0;
      beat_d    = '0;
    end else begin
      if (push) begin
        if (in_col_q == COL_LAST) begin
          in_col_d = '0;
          in_row_d = in_row_q + ROW_W'(1);
        end else begin
          in_col_d = in_col_q + COL_W'(1);
        end
      end
      if (emit) begin
        if (ctr_col_q == COL_LAST) begin
          ctr_col_d = '0;
          ctr_row_d = ctr_row_q + ROW_W'(1);
        end else begin
          ctr_col_d = ctr_col_q + COL_W'(1);
        end
      end
      if (beat_acc)
        beat_d = beat_q + BEAT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_col_q  <= '0;
      in_row_q  <= '0;
      ctr_col_q <= '0;
      ctr_row_q <= '0;
      beat_q    <= '0;
    end else begin
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      ctr_col_q <= ctr_col_d;
      ctr_row_q <= ctr_row_d;
      beat_q    <= beat_d;
    end
  end

  // Line buffers (read-before-write at the push column) and window shift.
  always_ff @(posedge clk) begin
    if (push) begin
      lb0_q[in_col_q] <= push_data;
      lb1_q[in_col_q] <= lb0_q[in_col_q];
      col_a_q         <= col_b_q;
      col_b_q         <= col_new;
    end
  end

  // Assemble the post-push window; border centres get a flat window so
  // every mode yields the border value regardless of stale neighbours.
  always_comb begin
    is_border   = (ctr_row_q == '0) | (ctr_row_q == ROW_LAST) |
                  (ctr_col_q == '0) | (ctr_col_q == COL_LAST);
    zero_border = (BORDER_MODE != 0) && (mode_q != MODE_BYP);
    border_val  = zero_border ? '0 : col_b_q[1];
    for (int r = 0; r < 3; r++) begin
      win[r*3 + 0] = col_a_q[2 - r];
      win[r*3 + 1] = col_b_q[2 - r];
      win[r*3 + 2] = col_new[2 - r];
    end
    if (is_border)
      win = {9{border_val}};
  end

  median9_sort #(
    .DATA_W (DATA_W)
  ) u_sort (
    .clk    (clk),
    .rst    (rst),
    .en_i   (~stall),
    .vld_i  (emit),
    .mode_i (mode_q),
    .win_i  (win),
    .vld_o  (out_valid),
    .data_o (out_data)
  );

endmodule

// File: tb/tb_median_filter_stream.sv
// Bench for median_filter_stream on a 5x4 frame, both border policies.
module tb_median_filter_stream;

  localparam int W       = 5;
  localparam int H       = 4;
  localparam int N       = W * H;
  localparam int CYC_MAX = 600;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, sel = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic [1:0] mode_s = 2'd0;
  logic [7:0] in_data = 8'd0;

  logic       start_a, start_b;
  logic       in_ready_a, out_valid_a, out_last_a, busy_a, done_a;
  logic       in_ready_b, out_valid_b, out_last_b, busy_b, done_b;
  logic [7:0] out_data_a, out_data_b;
  logic       in_ready_x, out_valid_x, out_last_x, busy_x, done_x;
  logic [7:0] out_data_x;

  logic [7:0] img [N];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign start_a     = start & ~sel;
  assign start_b     = start & sel;
  assign in_ready_x  = sel ? in_ready_b  : in_ready_a;
  assign out_valid_x = sel ? out_valid_b : out_valid_a;
  assign out_data_x  = sel ? out_data_b  : out_data_a;
  assign out_last_x  = sel ? out_last_b  : out_last_a;
  assign busy_x      = sel ? busy_b      : busy_a;
  assign done_x      = sel ? done_b      : done_a;

  median_filter_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .BORDER_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_s),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_last(out_last_a), .busy(busy_a), .done(done_a));

  median_filter_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .BORDER_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_s),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_last(out_last_b), .busy(busy_b), .done(done_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: gather the 3x3 neighbourhood, sort it, pick by rank.
  function automatic logic [7:0] ref_pix(input int md, input int bm, input int k);
    int r, c;
    logic [7:0] v[$];
    r = k / W;
    c = k % W;
    if (md == 3) return img[k];
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return (bm != 0) ? 8'h00 : img[k];
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        v.push_back(img[(r + dr) * W + c + dc]);
    v.sort();
    case (md)
      1:       return v[0];
      2:       return v[8];
      default: return v[4];
    endcase
  endfunction

  task automatic fill_ramp();
    for (int k = 0; k < N; k++) img[k] = 8'(k);
  endtask

  task automatic fill_impulse(input logic [7:0] v);
    for (int k = 0; k < N; k++) img[k] = 8'h40;
    img[2 * W + 2] = v;
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) img[k] = 8'($urandom_range(0, 255));
  endtask

  // Drive one frame with the given handshake densities and check every beat.
  task automatic run_frame(input string tag, input int md, input int rdy_pct,
                           input int vld_pct, input bit mid_start);
    int idx, nout, cyc;
    @(negedge clk);
    mode_s    = 2'(md);
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, busy_x, 1);
    idx = 0; nout = 0; cyc = 0;
    while (nout < N && cyc < CYC_MAX) begin
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      in_valid  = (idx < N) && ($urandom_range(0, 99) < vld_pct);
      in_data   = (idx < N) ? img[idx] : 8'h00;
      start     = mid_start && (cyc == 6);
      mode_s    = start ? 2'(md ^ 3) : 2'(md);
      #1;
      if (out_valid_x && !out_ready)
        check($sformatf("%s stall_in_ready cyc %0d", tag, cyc), in_ready_x, 0);
      if (in_valid && in_ready_x) idx++;
      if (out_valid_x && out_ready) begin
        check($sformatf("%s beat %0d data", tag, nout), out_data_x, ref_pix(md, int'(sel), nout));
        check($sformatf("%s beat %0d last", tag, nout), out_last_x, (nout == N - 1));
        nout++;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mode_s    = 2'(md);
    check({tag, " beats_received"}, nout, N);
    check({tag, " done_pulse"}, done_x, 1);
    check({tag, " busy_in_done"}, busy_x, 1);
    @(negedge clk);
    check({tag, " done_cleared"}, done_x, 0);
    check({tag, " busy_cleared"}, busy_x, 0);
    check({tag, " no_extra_beat"}, out_valid_x, 0);
  endtask

  initial begin
    int acc, cyc, seen;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("rst in_ready",  in_ready_a, 0);
    check("rst out_valid", out_valid_a, 0);
    check("rst out_data",  out_data_a, 0);
    check("rst out_last",  out_last_a, 0);
    check("rst busy",      busy_a, 0);
    check("rst done",      done_a, 0);
    check("rst b busy",    busy_b, 0);
    check("rst b valid",   out_valid_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp through the median: linear data returns the centre everywhere.
    sel = 1'b0;
    fill_ramp();
    run_frame("t1_ramp_med", 0, 100, 100, 1'b0);

    // Impulse on a flat field.
    fill_impulse(8'hFF);
    run_frame("t2_imp_med", 0, 100, 100, 1'b0);
    run_frame("t3_imp_max", 2, 100, 100, 1'b0);
    fill_impulse(8'h00);
    run_frame("t3_imp_min", 1, 100, 100, 1'b0);

    // Ramp with random back-pressure and gaps.
    fill_ramp();
    run_frame("t4_ramp_hs", 0, 50, 50, 1'b0);

    // Reset mid-frame after 7 accepted pixels.
    fill_ramp();
    @(negedge clk);
    mode_s = 2'd0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 7 && cyc < 50) begin
      in_valid = 1'b1;
      in_data  = img[acc];
      #1;
      if (in_ready_x) acc++;
      @(negedge clk);
      cyc++;
    end
    check("t5 accepts_before_rst", acc, 7);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t5 rst in_ready",  in_ready_a, 0);
    check("t5 rst out_valid", out_valid_a, 0);
    check("t5 rst busy",      busy_a, 0);
    check("t5 rst out_data",  out_data_a, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_a) seen++;
    end
    check("t5 no_done_after_rst", seen, 0);
    check("t5 idle_after_rst", busy_a, 0);
    run_frame("t5_after_rst", 0, 100, 100, 1'b0);

    // Zeroed borders, with a start pulse (and mode change) during RUN.
    sel = 1'b1;
    fill_ramp();
    run_frame("t6_border0", 0, 100, 100, 1'b1);

    // Random images, modes and handshakes.
    sel = 1'b0;
    for (int t = 0; t < 3; t++) begin
      fill_random();
      run_frame($sformatf("rnd_a%0d", t), int'($urandom_range(0, 3)), 70, 70, 1'b0);
    end
    sel = 1'b1;
    for (int t = 0; t < 2; t++) begin
      fill_random();
      run_frame($sformatf("rnd_b%0d", t), int'($urandom_range(0, 2)), 60, 80, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
